// File: rtl/seg7_scan_mux_if.sv
// ----------------------------------------------------------------------------
// seg7_scan_mux_if
// Bundles the load/display signals of the 4-digit seven-segment scan driver.
//   load  : single-cycle strobe that captures value/dp
//   value : 16-bit hex value, nibble k shown on digit k (digit 0 rightmost)
//   dp    : per-digit decimal-point enable, active-high
//   lzb   : leading-zero blanking enable (live, not latched)
//   busy  : a loaded value is waiting for the frame boundary
//   x     : nibble of the scanned digit, feeds hexto7segment.x
//   an    : anode enables, active-low
//   dp_n  : decimal point of the scanned digit, active-low
// master drives load/value/dp/lzb; slave is the scan driver.
// ----------------------------------------------------------------------------
interface seg7_scan_mux_if;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lzb;
    logic        busy;
    logic [3:0]  x;
    logic [3:0]  an;
    logic        dp_n;

    modport master (
        output load, value, dp, lzb,
        input  busy, x, an, dp_n
    );

    modport slave (
        input  load, value, dp, lzb,
        output busy, x, an, dp_n
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// ----------------------------------------------------------------------------
// seg7_scan_mux
// Time-multiplexed 4-digit scan driver placed in front of hexto7segment.
// A loaded value is held pending and only committed to the displayed shadow
// register at a frame boundary, so a frame never mixes old and new digits.
//   REFRESH_DIV : clock cycles each digit is held (2 .. 2^20)
//   clk         : system clock, rising edge
//   rst         : synchronous reset, active-high
//   bus         : seg7_scan_mux_if.slave (load/value/dp/lzb in,
//                 busy/x/an/dp_n out)
// ----------------------------------------------------------------------------
module seg7_scan_mux #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    seg7_scan_mux_if.slave       bus
);
    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [15:0]   r_shadow_val;
    logic [3:0]    r_shadow_dp;
    logic [19:0]   r_pend;
    logic          r_pend_v;
    logic [3:0]    r_x;
    logic [3:0]    r_an;
    logic          r_dp_n;

    logic          w_tick;
    logic          w_wrap;
    logic          w_blank;
    logic [3:0]    w_nib;

    // Digit k is blanked when it and every more-significant nibble are zero.
    function automatic logic is_blank(input logic [1:0] k,
                                      input logic [15:0] v,
                                      input logic en);
        logic b;
        case (k)
            2'd1:    b = (v[15:4]  == 12'h000);
            2'd2:    b = (v[15:8]  == 8'h00);
            2'd3:    b = (v[15:12] == 4'h0);
            default: b = 1'b0;
        endcase
        return en && b;
    endfunction

    assign w_tick  = (r_presc == PRESC_LAST);
    assign w_wrap  = w_tick && (r_idx == 2'd3);
    assign w_nib   = 4'(r_shadow_val >> {r_idx, 2'b00});
    assign w_blank = is_blank(r_idx, r_shadow_val, bus.lzb);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc      <= '0;
            r_idx        <= 2'd0;
            r_shadow_val <= 16'h0000;
            r_shadow_dp  <= 4'h0;
            r_pend       <= 20'h00000;
            r_pend_v     <= 1'b0;
            r_x          <= 4'h0;
            r_an         <= 4'b1111;
            r_dp_n       <= 1'b1;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) begin
                r_idx <= r_idx + 2'd1;
            end

            // A load landing on the boundary bypasses the pending register;
            // otherwise the boundary commits whatever is pending.
            if (bus.load && w_wrap) begin
                r_shadow_val <= bus.value;
                r_shadow_dp  <= bus.dp;
                r_pend_v     <= 1'b0;
            end else if (w_wrap && r_pend_v) begin
                r_shadow_val <= r_pend[19:4];
                r_shadow_dp  <= r_pend[3:0];
                r_pend_v     <= 1'b0;
            end else if (bus.load) begin
                r_pend   <= {bus.value, bus.dp};
                r_pend_v <= 1'b1;
            end

            // All three outputs come from the same idx so they switch together.
            r_x    <= w_nib;
            r_an   <= w_blank ? 4'b1111 : ~(4'b0001 << r_idx);
            r_dp_n <= w_blank ? 1'b1 : ~r_shadow_dp[r_idx];
        end
    end

    assign bus.busy = r_pend_v;
    assign bus.x    = r_x;
    assign bus.an   = r_an;
    assign bus.dp_n = r_dp_n;
endmodule
